mem_log_trig: RTL and testbench
===============================

Name: mem_log_trig

Overview:
- Parametrised successor of the single-shot IQ memory logger.
- Captures N_CH packed channel samples from the filter path into an internal single-port BRAM.
- Adds per-sample valid qualification, programmable decimation, and two capture modes: one-shot fill, and circular pre-/post-trigger.
- Exposes a logical (capture-relative) read port toward the 32-bit register/UART readout bus.

Parameters:
- ADDR_WIDTH, 15: BRAM address width; DEPTH = 2**ADDR_WIDTH samples.
- CH_WIDTH, 8: bits per channel.
- N_CH, 2: channel count; stored word is N_CH*CH_WIDTH bits (must be <= 32), channel 0 in the LSBs.
- DECIM_WIDTH, 8: width of the decimation ratio.

Ports:
- clk  in  1  single clock.
- i_rst_n  in  1  synchronous, active-low reset.
- i_data  in  N_CH*CH_WIDTH  packed channel samples.
- i_data_valid  in  1  sample qualifier.
- i_run_log  in  1  start/restart capture (level sampled each clk).
- i_stop  in  1  abort to IDLE.
- i_read_log  in  1  enter readout.
- i_mode  in  1  0 = one-shot fill, 1 = circular with trigger; latched on RUN entry.
- i_trigger  in  1  trigger strobe (mode 1 only).
- i_pretrig  in  ADDR_WIDTH  pre-trigger sample count; latched on RUN entry, clamped to DEPTH-1.
- i_decim  in  DECIM_WIDTH  keep 1 of (i_decim+1) valid samples; latched on RUN entry.
- i_rd_en  in  1  read request strobe.
- i_rd_addr  in  ADDR_WIDTH  logical read address; 0 = oldest captured sample.
- o_mem_full  out  1  capture complete.
- o_busy  out  1  high in RUN or POST.
- o_trig_addr  out  ADDR_WIDTH  physical address of the first post-trigger sample.
- o_rd_data  out  32  read data, zero-extended.
- o_rd_valid  out  1  read data strobe.
- o_drop_cnt  out  16  dropped-sample count (see Optional Feature).

Behaviour:
- Reset (i_rst_n=0 at a clk edge):
  - state = IDLE; write pointer, fill count, decimation counter, start address and o_trig_addr all = 0.
  - All outputs = 0.
  - BRAM contents are not cleared.
  - Reset wins over every other input.
- States: IDLE, RUN, POST, FULL, READ.
- Transitions:
  - IDLE -> RUN on i_run_log.
  - RUN -> FULL (mode 0) on the cycle the sample at address DEPTH-1 is accepted.
  - RUN -> POST (mode 1) on an accepted trigger.
  - POST -> FULL when the post-trigger count is reached.
  - FULL -> READ on i_read_log.
  - READ -> RUN on i_run_log.
  - i_run_log is ignored in FULL.
- i_stop in any non-IDLE state -> IDLE, and o_mem_full clears. i_stop has priority over i_run_log, i_trigger and i_read_log in the same cycle.
- Entering RUN:
  - Pointers, fill count and decimation counter clear; o_mem_full clears.
  - i_mode, i_pretrig and i_decim are latched.
- Sample acceptance (RUN/POST only):
  - A sample is accepted when i_data_valid=1 and the decimation counter = 0.
  - The counter advances on every valid sample, wrapping from the latched i_decim to 0. i_decim=0 accepts every valid sample.
  - An accepted sample is written at the write pointer in that cycle; the pointer increments and wraps DEPTH-1 -> 0.
  - The fill count saturates at DEPTH.
- Mode 1 trigger:
  - A trigger is accepted only in RUN, and only when fill count >= the latched pretrig. Earlier triggers are ignored with no state change.
  - On acceptance: o_trig_addr = current write pointer; start = o_trig_addr - pretrig (mod DEPTH).
  - POST writes exactly DEPTH - pretrig accepted samples, the first at o_trig_addr, then moves to FULL.
  - If an accepted sample and the trigger occur in the same cycle, that sample is the first post-trigger sample.
- Mode 0: start = 0; o_trig_addr stays 0.
- No writes occur in IDLE, FULL or READ.
- o_mem_full = 1 in FULL and READ, 0 otherwise. It is registered and rises the cycle after the final write.
- Readout:
  - i_rd_en is honoured only in READ.
  - Physical address = start + i_rd_addr (mod DEPTH).
  - Latency is 2 clks (BRAM registered read plus output register): o_rd_valid pulses 1 cycle with o_rd_data exactly 2 cycles after i_rd_en.
  - Back-to-back i_rd_en gives one result per cycle.
  - o_rd_data holds its last value when o_rd_valid=0.
  - A read in flight when leaving READ is discarded (o_rd_valid stays 0).

Optional Feature:
- Macro: MEMLOG_DROP_CNT_EN.
- Defined:
  - o_drop_cnt counts i_data_valid cycles seen in FULL or READ, saturating at 16'hFFFF.
  - It clears on RUN entry and on reset.
- Undefined: o_drop_cnt is tied to 0 and no counter logic is synthesised.

Test Plan (ADDR_WIDTH=4, DEPTH=16, CH_WIDTH=8, N_CH=2):
- Mode 0, decim 0, 16 valid samples 0x0100..0x010F: o_mem_full rises 1 clk after the 16th write. i_read_log, then reads at addr 0..15 return 0x00000100..0x0000010F, each with o_rd_valid exactly 2 clks after i_rd_en.
- Mode 0, decim 2, 48 samples with value k (k=0..47), with i_data_valid dropped every 5th cycle: stored values are 0,3,6,...,45 and full follows the 16th kept sample.
- Mode 1, pretrig 4, samples k=0..30, trigger with k=10: o_trig_addr=10, full after k=21; logical reads 0->6, 4->10, 15->21.
- Mode 1, pretrig 4, trigger with k=2: ignored and state stays RUN; a second trigger at k=8 is accepted, giving logical read 0 -> 4.
- i_stop asserted with i_trigger in RUN -> IDLE, no POST entry; i_rst_n=0 mid-READ with i_rd_en pending -> all outputs 0, no o_rd_valid.
- MEMLOG_DROP_CNT_EN defined, 7 valid cycles in FULL/READ -> o_drop_cnt=7; i_run_log -> 0. Undefined -> o_drop_cnt stays 0.

Source files
------------

// File: rtl/mem_log_trig.sv
// rtl/mem_log_trig.sv - triggered multi-channel sample logger with circular pre-trigger capture
// Optional macro MEMLOG_DROP_CNT_EN: counts valid samples that arrive while the buffer is full or being read.
module mem_log_trig #(
    parameter int ADDR_WIDTH  = 15,
    parameter int CH_WIDTH    = 8,
    parameter int N_CH        = 2,
    parameter int DECIM_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic [N_CH*CH_WIDTH-1:0] i_data,
    input  logic                     i_data_valid,
    input  logic                     i_run_log,
    input  logic                     i_stop,
    input  logic                     i_read_log,
    input  logic                     i_mode,
    input  logic                     i_trigger,
    input  logic [ADDR_WIDTH-1:0]    i_pretrig,
    input  logic [DECIM_WIDTH-1:0]   i_decim,
    input  logic                     i_rd_en,
    input  logic [ADDR_WIDTH-1:0]    i_rd_addr,
    output logic                     o_mem_full,
    output logic                     o_busy,
    output logic [ADDR_WIDTH-1:0]    o_trig_addr,
    output logic [31:0]              o_rd_data,
    output logic                     o_rd_valid,
    output logic [15:0]              o_drop_cnt
);
    localparam int DW    = N_CH * CH_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_POST, S_FULL, S_READ} state_t;

    state_t                  state;
    logic                    mode_q;
    logic [ADDR_WIDTH-1:0]   pretrig_q;
    logic [DECIM_WIDTH-1:0]  decim_q;
    logic [DECIM_WIDTH-1:0]  decim_cnt;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [ADDR_WIDTH-1:0]   start_addr;
    logic [ADDR_WIDTH:0]     fill_cnt;
    logic [ADDR_WIDTH:0]     post_cnt;
    logic [DW-1:0]           mem [DEPTH];
    logic [DW-1:0]           mem_q;
    logic                    rd_s1;

    logic                    capturing;
    logic                    accept;
    logic                    trig_ok;
    logic                    run_entry;
    logic                    leave_read;
    logic                    rd_req;
    logic                    wr_en;
    logic [ADDR_WIDTH:0]     post_len;

    assign capturing  = (state == S_RUN) || (state == S_POST);
    assign accept     = capturing && i_data_valid && (decim_cnt == '0);
    // The fill count is the pre-edge value, so a sample arriving with the trigger does not count toward pretrig.
    assign trig_ok    = (state == S_RUN) && mode_q && i_trigger && (fill_cnt >= {1'b0, pretrig_q});
    assign run_entry  = i_run_log && !i_stop && ((state == S_IDLE) || (state == S_READ));
    assign leave_read = (state == S_READ) && (i_stop || i_run_log);
    assign rd_req     = (state == S_READ) && !leave_read && i_rd_en;
    assign wr_en      = i_rst_n && !i_stop && accept;
    // pretrig is ADDR_WIDTH bits wide, so it never exceeds DEPTH-1 and the post length is at least 1.
    assign post_len   = DEPTH_C - {1'b0, pretrig_q};
    assign o_busy     = capturing;

    // Capture FSM: mode latching, decimation, write pointer, trigger handling and completion.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            mode_q      <= 1'b0;
            pretrig_q   <= '0;
            decim_q     <= '0;
            decim_cnt   <= '0;
            wr_ptr      <= '0;
            fill_cnt    <= '0;
            post_cnt    <= '0;
            start_addr  <= '0;
            o_trig_addr <= '0;
            o_mem_full  <= 1'b0;
        end else if (i_stop) begin
            state      <= S_IDLE;
            o_mem_full <= 1'b0;
        end else if (run_entry) begin
            state       <= S_RUN;
            mode_q      <= i_mode;
            pretrig_q   <= i_pretrig;
            decim_q     <= i_decim;
            decim_cnt   <= '0;
            wr_ptr      <= '0;
            fill_cnt    <= '0;
            post_cnt    <= '0;
            start_addr  <= '0;
            o_trig_addr <= '0;
            o_mem_full  <= 1'b0;
        end else begin
            if (capturing && i_data_valid)
                decim_cnt <= (decim_cnt == decim_q) ? '0 : decim_cnt + 1'b1;
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (fill_cnt != DEPTH_C)
                    fill_cnt <= fill_cnt + 1'b1;
            end
            case (state)
                S_RUN: begin
                    if (!mode_q) begin
                        if (accept && (&wr_ptr)) begin
                            state      <= S_FULL;
                            o_mem_full <= 1'b1;
                        end
                    end else if (trig_ok) begin
                        o_trig_addr <= wr_ptr;
                        start_addr  <= wr_ptr - pretrig_q;
                        // A sample accepted with the trigger is the first post-trigger sample.
                        if (accept && (post_len == 1)) begin
                            state      <= S_FULL;
                            o_mem_full <= 1'b1;
                        end else begin
                            state    <= S_POST;
                            post_cnt <= accept ? post_len - 1'b1 : post_len;
                        end
                    end
                end
                S_POST: begin
                    if (accept) begin
                        if (post_cnt == 1) begin
                            state      <= S_FULL;
                            o_mem_full <= 1'b1;
                        end else begin
                            post_cnt <= post_cnt - 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (i_read_log)
                        state <= S_READ;
                end
                default: ;
            endcase
        end
    end

    // Sample buffer: plain single-port-style BRAM with registered read, no reset so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= i_data;
        if (rd_req)
            mem_q <= mem[start_addr + i_rd_addr];
    end

    // Read pipeline: a request in flight is dropped if READ is left before it completes.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            rd_s1      <= 1'b0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            rd_s1      <= rd_req;
            o_rd_valid <= rd_s1 && (state == S_READ) && !leave_read;
            if (rd_s1 && (state == S_READ) && !leave_read)
                o_rd_data <= 32'(mem_q);
        end
    end

`ifdef MEMLOG_DROP_CNT_EN
    logic [15:0] drop_cnt;

    // Dropped-sample counter: valid input seen while capture is complete, saturating.
    always_ff @(posedge clk) begin
        if (!i_rst_n)
            drop_cnt <= '0;
        else if (run_entry)
            drop_cnt <= '0;
        else if (((state == S_FULL) || (state == S_READ)) && i_data_valid && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 1'b1;
    end

    assign o_drop_cnt = drop_cnt;
`else
    assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_log_trig.sv
// tb/tb_mem_log_trig.sv - directed self-checking bench for mem_log_trig
module tb_mem_log_trig;
    localparam int AW = 4;
`ifdef MEMLOG_DROP_CNT_EN
    localparam logic [31:0] DROP_EXP = 32'd7;
`else
    localparam logic [31:0] DROP_EXP = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic [15:0]   i_data = '0;
    logic          i_data_valid = 1'b0;
    logic          i_run_log = 1'b0;
    logic          i_stop = 1'b0;
    logic          i_read_log = 1'b0;
    logic          i_mode = 1'b0;
    logic          i_trigger = 1'b0;
    logic [AW-1:0] i_pretrig = '0;
    logic [7:0]    i_decim = '0;
    logic          i_rd_en = 1'b0;
    logic [AW-1:0] i_rd_addr = '0;
    logic          o_mem_full;
    logic          o_busy;
    logic [AW-1:0] o_trig_addr;
    logic [31:0]   o_rd_data;
    logic          o_rd_valid;
    logic [15:0]   o_drop_cnt;

    int total = 0;
    int bad = 0;

    mem_log_trig #(.ADDR_WIDTH(AW), .CH_WIDTH(8), .N_CH(2), .DECIM_WIDTH(8)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_data_valid(i_data_valid),
        .i_run_log(i_run_log), .i_stop(i_stop), .i_read_log(i_read_log), .i_mode(i_mode),
        .i_trigger(i_trigger), .i_pretrig(i_pretrig), .i_decim(i_decim), .i_rd_en(i_rd_en),
        .i_rd_addr(i_rd_addr), .o_mem_full(o_mem_full), .o_busy(o_busy),
        .o_trig_addr(o_trig_addr), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic mode, input logic [AW-1:0] pre, input logic [7:0] dec);
        i_mode = mode; i_pretrig = pre; i_decim = dec; i_run_log = 1'b1;
        tick();
        i_run_log = 1'b0;
    endtask

    task automatic enter_read();
        i_read_log = 1'b1;
        tick();
        i_read_log = 1'b0;
    endtask

    task automatic rd_one(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        i_rd_en = 1'b1; i_rd_addr = a;
        tick();
        i_rd_en = 1'b0;
        chk({tag, "_v1"}, {31'd0, o_rd_valid}, 32'd0);
        tick();
        chk({tag, "_v2"}, {31'd0, o_rd_valid}, 32'd1);
        chk({tag, "_d"}, o_rd_data, exp);
        tick();
        chk({tag, "_v3"}, {31'd0, o_rd_valid}, 32'd0);
    endtask

    initial begin
        int k;
        int c;
        logic [31:0] exp_v;

        // reset state
        tick(); tick();
        chk("rst_full", {31'd0, o_mem_full}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_trig", {28'd0, o_trig_addr}, 32'd0);
        chk("rst_rdv", {31'd0, o_rd_valid}, 32'd0);
        chk("rst_rdd", o_rd_data, 32'd0);
        chk("rst_drop", {16'd0, o_drop_cnt}, 32'd0);
        i_rst_n = 1'b1;
        tick();

        // mode 0, decim 0, 16 samples then back-to-back reads
        start_run(1'b0, 4'd0, 8'd0);
        chk("m0_busy", {31'd0, o_busy}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            i_data = 16'h0100 + 16'(i); i_data_valid = 1'b1;
            tick();
            chk($sformatf("m0_full_%0d", i), {31'd0, o_mem_full}, (i == 15) ? 32'd1 : 32'd0);
        end
        i_data_valid = 1'b0;
        chk("m0_idlebusy", {31'd0, o_busy}, 32'd0);
        enter_read();
        chk("m0_rdfull", {31'd0, o_mem_full}, 32'd1);
        for (int j = 0; j < 18; j++) begin
            if (j < 16) begin i_rd_en = 1'b1; i_rd_addr = AW'(j); end
            else i_rd_en = 1'b0;
            tick();
            exp_v = (j >= 1 && j <= 16) ? 32'd1 : 32'd0;
            chk($sformatf("m0_b2b_v%0d", j), {31'd0, o_rd_valid}, exp_v);
            if (j >= 1 && j <= 16)
                chk($sformatf("m0_b2b_d%0d", j), o_rd_data, 32'h100 + 32'(j - 1));
        end

        // mode 0, decim 2, valid dropped every 5th cycle
        start_run(1'b0, 4'd0, 8'd2);
        k = 0; c = 0;
        while (k < 48 && c < 200) begin
            i_data = 16'(k); i_data_valid = (c % 5 != 4);
            tick();
            if (c % 5 != 4) begin
                if (k == 44) chk("dec_full44", {31'd0, o_mem_full}, 32'd0);
                if (k == 45) chk("dec_full45", {31'd0, o_mem_full}, 32'd1);
                k++;
            end
            c++;
        end
        i_data_valid = 1'b0;
        enter_read();
        rd_one("dec_r0", 4'd0, 32'd0);
        rd_one("dec_r1", 4'd1, 32'd3);
        rd_one("dec_r7", 4'd7, 32'd21);
        rd_one("dec_r15", 4'd15, 32'd45);

        // mode 1, pretrig 4, trigger with k=10
        start_run(1'b1, 4'd4, 8'd0);
        for (int i = 0; i <= 30; i++) begin
            i_data = 16'(i); i_data_valid = 1'b1; i_trigger = (i == 10);
            tick();
            i_trigger = 1'b0;
            if (i == 10) begin
                chk("t1_trig", {28'd0, o_trig_addr}, 32'd10);
                chk("t1_busy", {31'd0, o_busy}, 32'd1);
            end
            if (i == 20) chk("t1_full20", {31'd0, o_mem_full}, 32'd0);
            if (i == 21) chk("t1_full21", {31'd0, o_mem_full}, 32'd1);
        end
        i_data_valid = 1'b0;
        enter_read();
        rd_one("t1_r0", 4'd0, 32'd6);
        rd_one("t1_r4", 4'd4, 32'd10);
        rd_one("t1_r15", 4'd15, 32'd21);

        // mode 1, early trigger ignored, second trigger accepted
        start_run(1'b1, 4'd4, 8'd0);
        chk("t2_drop_clr", {16'd0, o_drop_cnt}, 32'd0);
        for (int i = 0; i <= 19; i++) begin
            i_data = 16'(i); i_data_valid = 1'b1; i_trigger = (i == 2 || i == 8);
            tick();
            i_trigger = 1'b0;
            if (i == 2) chk("t2_run_k2", {31'd0, o_busy}, 32'd1);
            if (i == 8) chk("t2_trig", {28'd0, o_trig_addr}, 32'd8);
            if (i == 13) chk("t2_full13", {31'd0, o_mem_full}, 32'd0);
            if (i == 19) chk("t2_full19", {31'd0, o_mem_full}, 32'd1);
        end
        i_data_valid = 1'b0;
        tick();
        chk("drop_pre", {16'd0, o_drop_cnt}, 32'd0);
        for (int i = 0; i < 7; i++) begin
            i_data = 16'hDEAD; i_data_valid = 1'b1;
            tick();
        end
        i_data_valid = 1'b0;
        chk("drop_cnt", {16'd0, o_drop_cnt}, DROP_EXP);
        enter_read();
        rd_one("t2_r0", 4'd0, 32'd4);
        rd_one("t2_r15", 4'd15, 32'd19);

        // read in flight discarded when READ is left; drop counter clears on RUN entry
        i_rd_en = 1'b1; i_rd_addr = 4'd0;
        tick();
        i_rd_en = 1'b0;
        i_mode = 1'b1; i_pretrig = 4'd0; i_decim = 8'd0; i_run_log = 1'b1;
        tick();
        i_run_log = 1'b0;
        chk("disc_v1", {31'd0, o_rd_valid}, 32'd0);
        tick();
        chk("disc_v2", {31'd0, o_rd_valid}, 32'd0);
        chk("drop_clr", {16'd0, o_drop_cnt}, 32'd0);
        chk("run2_busy", {31'd0, o_busy}, 32'd1);

        // stop beats trigger in RUN
        for (int i = 0; i < 3; i++) begin
            i_data = 16'(i); i_data_valid = 1'b1;
            tick();
        end
        i_stop = 1'b1; i_trigger = 1'b1;
        tick();
        i_stop = 1'b0; i_trigger = 1'b0; i_data_valid = 1'b0;
        chk("stop_busy", {31'd0, o_busy}, 32'd0);
        chk("stop_full", {31'd0, o_mem_full}, 32'd0);
        tick();
        chk("stop_idle", {31'd0, o_busy}, 32'd0);

        // reset mid-READ with a read pending
        start_run(1'b0, 4'd0, 8'd0);
        for (int i = 0; i < 16; i++) begin
            i_data = 16'h0200 + 16'(i); i_data_valid = 1'b1;
            tick();
        end
        i_data_valid = 1'b0;
        chk("r6_full", {31'd0, o_mem_full}, 32'd1);
        enter_read();
        rd_one("r6_r5", 4'd5, 32'h205);
        i_rd_en = 1'b1; i_rd_addr = 4'd3;
        tick();
        i_rd_en = 1'b0; i_rst_n = 1'b0;
        tick();
        chk("rr_rdv", {31'd0, o_rd_valid}, 32'd0);
        chk("rr_rdd", o_rd_data, 32'd0);
        chk("rr_full", {31'd0, o_mem_full}, 32'd0);
        chk("rr_busy", {31'd0, o_busy}, 32'd0);
        chk("rr_trig", {28'd0, o_trig_addr}, 32'd0);
        chk("rr_drop", {16'd0, o_drop_cnt}, 32'd0);
        tick();
        chk("rr_rdv2", {31'd0, o_rd_valid}, 32'd0);
        i_rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
